bcd_down_timer: RTL

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer_pkg.sv | 19 +
 rtl/bcd_down_timer_digit_dec.sv | 24 ++
 rtl/bcd_down_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the three-digit BCD down-timer.
package bcd_down_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_PAUSED = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int BCD_MAX = 9;
    localparam int PRESC_W = 26;

    // Out-of-range preset digits saturate at the largest legal BCD value.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'(BCD_MAX)) ? 4'(BCD_MAX) : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit_dec.sv
// One BCD digit of the borrow chain: subtracts borrow_in, wrapping 0 to 9.
module bcd_digit_dec
    import bcd_down_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_nxt,
    output logic       borrow_out
);

    always_comb begin
        digit_nxt  = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_nxt  = 4'(BCD_MAX);
                borrow_out = 1'b1;
            end else begin
                digit_nxt = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Three-digit BCD countdown timer with load, start/resume, pause and done.
//   state     | meaning
//   ST_IDLE   | value loaded or reset, waiting for start
//   ST_RUN    | prescaler counting, value decrements on each tick
//   ST_PAUSED | enable dropped; prescaler and value held
//   ST_DONE   | reached 000; only load leaves
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        start,
    input  logic        enable,
    output logic [3:0]  BCD0,
    output logic [3:0]  BCD1,
    output logic [3:0]  BCD2,
    output logic        running,
    output logic        done
);

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICK_DIV - 1);

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [3:0]           units_q, units_d;
    logic [3:0]           tens_q,  tens_d;
    logic [3:0]           hunds_q, hunds_d;

    logic                 tick;
    logic [3:0]           units_nxt, tens_nxt, hunds_nxt;
    logic                 borrow_u, borrow_t, borrow_h;
    logic                 value_zero, value_one;

    assign tick       = (state_q == ST_RUN) && enable && (presc_q == PRESC_TERM);
    assign value_zero = ({hunds_q, tens_q, units_q} == 12'h000);
    assign value_one  = ({hunds_q, tens_q, units_q} == 12'h001);

    bcd_digit_dec u_dec_units (
        .digit      (units_q),
        .borrow_in  (tick),
        .digit_nxt  (units_nxt),
        .borrow_out (borrow_u)
    );

    bcd_digit_dec u_dec_tens (
        .digit      (tens_q),
        .borrow_in  (borrow_u),
        .digit_nxt  (tens_nxt),
        .borrow_out (borrow_t)
    );

    bcd_digit_dec u_dec_hunds (
        .digit      (hunds_q),
        .borrow_in  (borrow_t),
        .digit_nxt  (hunds_nxt),
        .borrow_out (borrow_h)
    );

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        units_d = units_q;
        tens_d  = tens_q;
        hunds_d = hunds_q;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (start && enable)
                    state_d = value_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    // A borrow out of the hundreds digit means 000; never wrap.
                    if (!borrow_h) begin
                        units_d = units_nxt;
                        tens_d  = tens_nxt;
                        hunds_d = hunds_nxt;
                    end
                    if (value_one || value_zero)
                        state_d = ST_DONE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (start && enable)
                    state_d = ST_RUN;
            end
            ST_DONE: begin
                presc_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        if (load) begin
            state_d = ST_IDLE;
            presc_d = '0;
            units_d = clamp_bcd(load_value[3:0]);
            tens_d  = clamp_bcd(load_value[7:4]);
            hunds_d = clamp_bcd(load_value[11:8]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            hunds_q <= 4'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hunds_q <= hunds_d;
        end
    end

    assign BCD0    = units_q;
    assign BCD1    = tens_q;
    assign BCD2    = hunds_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule
